// File: rtl/nx_stat_counter_sw_responder_if.sv
// Software request/response channel of the stat-counter storage responder.
// The op encoding is shared by the responder and whatever drives the channel.

typedef enum logic [1:0] {
    OP_WRITE      = 2'd0,
    OP_READ       = 2'd1,
    OP_READ_CLEAR = 2'd2
} counter_op_e;

interface nx_stat_counter_sw_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 70
);
    logic              sw_req_valid;
    logic              sw_req_ready;
    logic [ADDR_W-1:0] sw_req_addr;
    logic [DATA_W-1:0] sw_req_data;
    counter_op_e       sw_req_op;
    logic              sw_rsp_valid;
    logic              sw_rsp_ready;
    logic [DATA_W-1:0] sw_rsp_data;

    modport master (
        output sw_req_valid, sw_req_addr, sw_req_data, sw_req_op, sw_rsp_ready,
        input  sw_req_ready, sw_rsp_valid, sw_rsp_data
    );

    modport slave (
        input  sw_req_valid, sw_req_addr, sw_req_data, sw_req_op, sw_rsp_ready,
        output sw_req_ready, sw_rsp_valid, sw_rsp_data
    );
endinterface

// File: rtl/nx_stat_counter_sw_responder.sv
// Packed saturating stat-counter storage with per-cycle hardware increments and
// an in-order software WRITE/READ/READ_CLEAR responder behind a small response FIFO.

module nx_stat_counter_sw_responder #(
    parameter int          N_ENTRIES            = 16,
    parameter int          N_COUNTERS_PER_ENTRY = 2,
    parameter int unsigned COUNTER_LSB_OFFSET [N_COUNTERS_PER_ENTRY:0] = '{70, 32, 0},
    parameter int          N_INC_BITS           = 8,
    parameter int          N_RSP_DEPTH          = 2,
    localparam int         W      = int'(COUNTER_LSB_OFFSET[N_COUNTERS_PER_ENTRY]),
    // One extra address bit so out-of-range requests are representable.
    localparam int         ADDR_W = $clog2(N_ENTRIES + 1),
    localparam int         INC_W  = N_COUNTERS_PER_ENTRY * N_INC_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_valid,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic [INC_W-1:0]  inc_amount,
    nx_stat_counter_sw_responder_if.slave sw
);

    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int PTR_W = (N_RSP_DEPTH > 1) ? $clog2(N_RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(N_RSP_DEPTH + 1);

    logic [W-1:0]     mem [N_ENTRIES];

    logic             inc_in_range;
    logic             sw_in_range;
    logic             sw_fire;
    logic             same_entry;
    logic [IDX_W-1:0] inc_idx;
    logic [IDX_W-1:0] sw_idx;

    logic [W-1:0]     inc_old;
    logic [W-1:0]     inc_new;
    logic [W-1:0]     sw_base;
    logic [W-1:0]     sw_new;
    logic [W-1:0]     sw_pre;
    logic [INC_W-1:0] sw_add;

    logic [W-1:0]     fifo [N_RSP_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;

    assign inc_in_range = (inc_addr < ADDR_W'(N_ENTRIES));
    assign sw_in_range  = (sw.sw_req_addr < ADDR_W'(N_ENTRIES));
    assign inc_idx      = inc_addr[IDX_W-1:0];
    assign sw_idx       = sw.sw_req_addr[IDX_W-1:0];
    assign sw_fire      = sw.sw_req_valid && sw.sw_req_ready;
    assign same_entry   = inc_valid && inc_in_range && sw_in_range && (inc_idx == sw_idx);

    // A colliding increment is folded into the software result so it is never lost.
    assign sw_add  = same_entry ? inc_amount : '0;
    assign inc_old = mem[inc_idx];
    assign sw_pre  = sw_in_range ? mem[sw_idx] : '0;

    always_comb begin
        sw_base = mem[sw_idx];
        case (sw.sw_req_op)
            OP_WRITE:      sw_base = sw.sw_req_data;
            OP_READ_CLEAR: sw_base = '0;
            default:       sw_base = mem[sw_idx];
        endcase
    end

    for (genvar i = 0; i < N_COUNTERS_PER_ENTRY; i++) begin : g_cnt
        localparam int LO = int'(COUNTER_LSB_OFFSET[i]);
        localparam int WI = int'(COUNTER_LSB_OFFSET[i+1]) - LO;

        logic [WI:0] inc_sum;
        logic [WI:0] sw_sum;

        assign inc_sum = {1'b0, inc_old[LO +: WI]}
                       + {{(WI + 1 - N_INC_BITS){1'b0}}, inc_amount[i*N_INC_BITS +: N_INC_BITS]};
        assign sw_sum  = {1'b0, sw_base[LO +: WI]}
                       + {{(WI + 1 - N_INC_BITS){1'b0}}, sw_add[i*N_INC_BITS +: N_INC_BITS]};

        assign inc_new[LO +: WI] = inc_sum[WI] ? {WI{1'b1}} : inc_sum[WI-1:0];
        assign sw_new[LO +: WI]  = sw_sum[WI]  ? {WI{1'b1}} : sw_sum[WI-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < N_ENTRIES; e++) begin
                mem[e] <= '0;
            end
        end else begin
            if (inc_valid && inc_in_range && !(sw_fire && same_entry)) begin
                mem[inc_idx] <= inc_new;
            end
            if (sw_fire && sw_in_range) begin
                mem[sw_idx] <= sw_new;
            end
        end
    end

    // Ready depends on occupancy only; a same-cycle pop does not free a slot early.
    assign full            = (count == CNT_W'(N_RSP_DEPTH));
    assign sw.sw_req_ready = !full;
    assign sw.sw_rsp_valid = (count != '0);
    assign sw.sw_rsp_data  = sw.sw_rsp_valid ? fifo[rd_ptr] : '0;
    assign push            = sw_fire;
    assign pop             = sw.sw_rsp_valid && sw.sw_rsp_ready;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int d = 0; d < N_RSP_DEPTH; d++) begin
                fifo[d] <= '0;
            end
        end else begin
            if (push) begin
                fifo[wr_ptr] <= sw_pre;
                wr_ptr       <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_nx_stat_counter_sw_responder.sv
// Directed bench for the stat-counter responder: expected responses are queued at
// issue time and a negedge monitor compares each one the DUT hands back.

module tb_nx_stat_counter_sw_responder;

    localparam int N_ENTRIES = 16;
    localparam int W         = 70;
    localparam int ADDR_W    = 5;
    localparam int INC_W     = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              inc_valid;
    logic [ADDR_W-1:0] inc_addr;
    logic [INC_W-1:0]  inc_amount;

    always #5 clk = ~clk;

    nx_stat_counter_sw_responder_if #(.ADDR_W(ADDR_W), .DATA_W(W)) sw_if ();

    nx_stat_counter_sw_responder dut (
        .clk        (clk),
        .reset      (reset),
        .inc_valid  (inc_valid),
        .inc_addr   (inc_addr),
        .inc_amount (inc_amount),
        .sw         (sw_if.slave)
    );

    logic [W-1:0] exp_q [$];
    logic [W-1:0] model [N_ENTRIES];
    int errors   = 0;
    int checks   = 0;
    int pushed   = 0;
    int rsp_seen = 0;

    function automatic logic [W-1:0] pack(input logic [37:0] c1, input logic [31:0] c0);
        return {c1, c0};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every handshake pops one expectation in order.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && sw_if.sw_rsp_valid && sw_if.sw_rsp_ready) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %0h expected no response", sw_if.sw_rsp_data);
                end else begin
                    check("rsp_data", sw_if.sw_rsp_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_inc(input logic [ADDR_W-1:0] a, input logic [INC_W-1:0] amt);
        inc_valid  = 1'b1;
        inc_addr   = a;
        inc_amount = amt;
        @(posedge clk);
        #1;
        inc_valid  = 1'b0;
    endtask

    task automatic sw_req(input counter_op_e op, input logic [ADDR_W-1:0] a,
                          input logic [W-1:0] d, input logic [W-1:0] e,
                          input logic iv = 1'b0, input logic [INC_W-1:0] ia = '0);
        logic got;
        sw_if.sw_req_valid = 1'b1;
        sw_if.sw_req_addr  = a;
        sw_if.sw_req_data  = d;
        sw_if.sw_req_op    = op;
        inc_valid          = iv;
        inc_addr           = a;
        inc_amount         = ia;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = sw_if.sw_req_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got ready=0 expected ready=1 within 50 cycles");
        end else begin
            exp_q.push_back(e);
            pushed++;
        end
        @(posedge clk);
        #1;
        sw_if.sw_req_valid = 1'b0;
        inc_valid          = 1'b0;
    endtask

    initial begin
        logic drained;
        reset              = 1'b1;
        inc_valid          = 1'b0;
        inc_addr           = '0;
        inc_amount         = '0;
        sw_if.sw_req_valid = 1'b0;
        sw_if.sw_req_addr  = '0;
        sw_if.sw_req_data  = '0;
        sw_if.sw_req_op    = OP_READ;
        sw_if.sw_rsp_ready = 1'b1;
        for (int e = 0; e < N_ENTRIES; e++) model[e] = '0;

        #2;
        check("reset_req_ready", W'(sw_if.sw_req_ready), W'(1));
        check("reset_rsp_valid", W'(sw_if.sw_rsp_valid), W'(0));
        check("reset_rsp_data", sw_if.sw_rsp_data, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fresh entry reads zero, response valid one cycle after acceptance.
        sw_req(OP_READ, 5'd3, '0, '0);
        @(negedge clk);
        check("latency_valid", W'(sw_if.sw_rsp_valid), W'(1));
        @(posedge clk);
        #1;

        repeat (5) do_inc(5'd5, {8'd1, 8'd2});
        model[5] = pack(38'd5, 32'd10);
        sw_req(OP_READ, 5'd5, '0, pack(38'd5, 32'd10));

        sw_req(OP_WRITE, 5'd7, pack(38'h12, 32'hFFFF_FFF0), '0);
        do_inc(5'd7, {8'd0, 8'h20});
        model[7] = pack(38'h12, 32'hFFFF_FFFF);
        sw_req(OP_READ, 5'd7, '0, pack(38'h12, 32'hFFFF_FFFF));

        sw_req(OP_WRITE, 5'd2, pack(38'd50, 32'd100), '0);
        sw_req(OP_READ_CLEAR, 5'd2, '0, pack(38'd50, 32'd100), 1'b1, {8'd4, 8'd3});
        model[2] = pack(38'd4, 32'd3);
        sw_req(OP_READ, 5'd2, '0, pack(38'd4, 32'd3));

        // Unused encoding behaves as READ; the data field must be ignored.
        sw_req(counter_op_e'(2'b11), 5'd5, pack(38'h3, 32'h7), pack(38'd5, 32'd10));

        // Read-after-write on consecutive cycles.
        sw_req(OP_WRITE, 5'd9, pack(38'd1, 32'd2), '0);
        sw_req(OP_READ, 5'd9, '0, pack(38'd1, 32'd2));
        model[9] = pack(38'd1, 32'd2);

        // Backpressure: two fill the buffer, third waits for the first pop.
        @(negedge clk);
        @(posedge clk);
        #1;
        sw_if.sw_rsp_ready = 1'b0;
        sw_if.sw_req_valid = 1'b1;
        sw_if.sw_req_op    = OP_READ;
        sw_if.sw_req_addr  = 5'd5;
        exp_q.push_back(model[5]);
        pushed++;
        @(posedge clk);
        #1;
        sw_if.sw_req_addr  = 5'd7;
        exp_q.push_back(model[7]);
        pushed++;
        @(posedge clk);
        #1;
        sw_if.sw_req_addr  = 5'd2;
        @(negedge clk);
        check("full_req_ready", W'(sw_if.sw_req_ready), W'(0));
        check("held_rsp_valid", W'(sw_if.sw_rsp_valid), W'(1));
        check("held_rsp_data", sw_if.sw_rsp_data, model[5]);
        repeat (2) @(negedge clk);
        check("held_rsp_data_later", sw_if.sw_rsp_data, model[5]);
        check("still_full_ready", W'(sw_if.sw_req_ready), W'(0));
        @(posedge clk);
        #1;
        sw_if.sw_rsp_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_ready", W'(sw_if.sw_req_ready), W'(0));
        @(negedge clk);
        check("after_pop_ready", W'(sw_if.sw_req_ready), W'(1));
        exp_q.push_back(model[2]);
        pushed++;
        @(posedge clk);
        #1;
        sw_if.sw_req_valid = 1'b0;

        // Out-of-range write: zero response, no entry touched.
        sw_req(OP_WRITE, 5'd16, {W{1'b1}}, '0);
        for (int e = 0; e < N_ENTRIES; e++) begin
            sw_req(OP_READ, ADDR_W'(e), '0, model[e]);
        end

        drained = 1'b0;
        for (int k = 0; k < 100 && !drained; k++) begin
            @(negedge clk);
            drained = (exp_q.size() == 0);
        end
        if (!drained) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        check("rsp_count", W'(rsp_seen), W'(pushed));
        check("final_rsp_valid", W'(sw_if.sw_rsp_valid), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nx_stat_counter_sw_responder.md
# nx_stat_counter_sw_responder

Counter-storage responder for the software stat-counter request/response channel. It holds `N_ENTRIES` entries of packed saturating counters and applies hardware increments every cycle. It also services software WRITE / READ / READ_CLEAR requests from the indirect-access control side, returning exactly one in-order response per accepted request. It sits between the block's event sources and the CSR indirect-access controller.

## Interface
Parameters:
- `N_ENTRIES`, 16, number of counter entries.
- `N_COUNTERS_PER_ENTRY`, 2, counters packed per entry.
- `COUNTER_LSB_OFFSET[N_COUNTERS_PER_ENTRY:0]`, '{70,32,0}, packed LSB of counter i. Counter i width is Wi = offset[i+1]-offset[i]. Total width W = offset[N_COUNTERS_PER_ENTRY].
- `N_INC_BITS`, 8, per-counter increment width (must be ≤ every Wi).
- `N_RSP_DEPTH`, 2, response buffer depth (≥1).

Ports:
- `clk` in 1 clock.
- `reset` in 1 asynchronous, active-high reset.
- `inc_valid` in 1 hardware increment strobe.
- `inc_addr` in LOG(N_ENTRIES) increment entry.
- `inc_amount` in N_COUNTERS_PER_ENTRY*N_INC_BITS, unsigned amount per counter; slice i is `[i*N_INC_BITS +: N_INC_BITS]`.
- `sw_req_valid` in 1 software request valid.
- `sw_req_ready` out 1 request accepted when high with valid.
- `sw_req_addr` in LOG(N_ENTRIES) request entry.
- `sw_req_data` in W, packed write data.
- `sw_req_op` in counter_op_e, WRITE / READ / READ_CLEAR.
- `sw_rsp_valid` out 1 response valid.
- `sw_rsp_ready` in 1 response consumed.
- `sw_rsp_data` out W, packed pre-operation entry value.

## Operation
- Storage: flop array, N_ENTRIES × W bits. Every counter is unsigned and saturates at all-ones. Sums are computed Wi+1 bits wide; a carry-out forces all-ones.
- Increment: when `inc_valid` is high and `inc_addr` < N_ENTRIES, counter i ← sat(old_i + inc_amount_i) at the clock edge. Increments are never back-pressured.
- SW accept: when `sw_req_valid` and `sw_req_ready` are high at an edge, the op executes on that edge, and the entry's pre-operation value is pushed into the response buffer.
  - WRITE: entry ← sat(wdata_i + same-cycle increment_i).
  - READ: entry unchanged (a same-cycle increment still applies).
  - READ_CLEAR: entry ← sat(0 + same-cycle increment_i). An increment arriving in the same cycle is never lost.
  - Any other encoding: treated as READ.
- Out-of-range `sw_req_addr` (≥ N_ENTRIES): accepted, response data all-zero, no state change.
- Every accepted request, including WRITE, yields exactly one response. Responses are returned in acceptance order, so an upstream in-flight counter drains.
- Response buffer: FIFO of N_RSP_DEPTH entries. `sw_req_ready` = !full; it is combinational from the FIFO count only and has no dependence on `sw_req_valid`. Pop occurs when `sw_rsp_valid` and `sw_rsp_ready` are high. Push and pop in the same cycle leave the count unchanged.
- `sw_rsp_data` is the FIFO head; it is held stable while valid and not ready.

## Timing
- Reset values: all counters 0, FIFO empty, `sw_rsp_valid`=0, `sw_rsp_data`=0, `sw_req_ready`=1.
- Reset asserted mid-operation: counters and buffered responses are discarded immediately; outputs return to reset values asynchronously.
- Latency: a request accepted at edge T has its response valid from T+1 when the FIFO is empty. Otherwise it appears after the earlier responses.
- Throughput: one request per cycle while `sw_rsp_ready`=1. With N_RSP_DEPTH=2 and `sw_rsp_ready` tied high, `sw_req_ready` never drops.
- Read-after-write to the same entry on consecutive cycles: the second request sees the value written at the first edge, with no hazard.
- Full FIFO with a pop in the same cycle: `sw_req_ready` stays 0 that cycle, because there is no pop pass-through.

## Test plan
- After reset, READ entry 3 → response at T+1 = 70'h0; `sw_req_ready`=1 throughout.
- Apply 5 increments of {8'd2, 8'd1} to entry 5, then READ → response counter0=10, counter1=5.
- WRITE entry 7 with counter0=32'hFFFF_FFF0, then increment counter0 by 8'h20 → READ shows counter0=32'hFFFF_FFFF (saturated). counter1 is unaffected.
- READ_CLEAR entry 2 (value 100/50) in the same cycle as an increment {3,4} to entry 2 → response 100/50; a following READ gives 3/4.
- Hold `sw_rsp_ready`=0 and issue 3 back-to-back requests → 2 accepted, `sw_req_ready`=0. Then release → responses drain in order, and the third request is accepted the cycle after the first pop.
- Issue WRITE to address N_ENTRIES (16) → one response with data 0, and no entry is modified (verified by a full-array readback).
